// File: rtl/nonres_div_pkg.sv
// Shared types for the non-restoring divider remainder fixup stage.
// NONRES_FIXUP_SELFCHECK_EN adds the original dividend to the raw bundle.
package nonres_div_pkg;

    localparam int DW = 2;
    localparam int RW = 4;
    localparam int QW = RW - DW + 1;
    localparam int CW = RW + 2;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [QW-1:0] q;
        logic [RW:0]   r_n1;
`ifdef NONRES_FIXUP_SELFCHECK_EN
        logic [RW-1:0] r_0;
`endif
    } nrd_raw_t;

    typedef struct packed {
        logic [QW-1:0] quo;
        logic [DW-1:0] rem;
        logic          fixed;
        logic          dz;
    } nrd_res_t;

`ifdef NONRES_FIXUP_SELFCHECK_EN
    // Rebuilds the dividend from a finished result, wide enough not to wrap.
    function automatic logic [CW-1:0] recombine(
        input logic [QW-1:0] quo,
        input logic [DW-1:0] d,
        input logic [DW-1:0] rem
    );
        logic [CW-1:0] prod;
        prod = CW'(quo) * CW'(d);
        return prod + CW'(rem);
    endfunction
`endif

endpackage

// File: rtl/nonres_div_rem_fixup_restore.sv
// Combinational remainder restoration: adds the divisor back to a
// negative partial remainder and flags divide-by-zero.
module nonres_rem_restore
    import nonres_div_pkg::*;
(
    input  nrd_raw_t raw,
    output nrd_res_t res
);

    logic          dz;
    logic          neg;
    logic [DW-1:0] add_rem;

    // Only the low DW bits of the restored sum can be a valid remainder.
    always_comb begin
        dz      = (raw.d == '0);
        neg     = raw.r_n1[RW];
        add_rem = raw.r_n1[DW-1:0] + raw.d;
        res     = '0;
        unique case (1'b1)
            dz: begin
                res.quo   = '1;
                res.rem   = raw.r_n1[DW-1:0];
                res.fixed = 1'b0;
                res.dz    = 1'b1;
            end
            !dz && neg: begin
                res.quo   = raw.q;
                res.rem   = add_rem;
                res.fixed = 1'b1;
                res.dz    = 1'b0;
            end
            default: begin
                res.quo   = raw.q;
                res.rem   = raw.r_n1[DW-1:0];
                res.fixed = 1'b0;
                res.dz    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/nonres_div_rem_fixup.sv
// Two-register valid/ready fixup stage behind the non-restoring divider.
// NONRES_FIXUP_SELFCHECK_EN adds R_0 input and sticky chk_err output.
module nonres_div_rem_fixup
    import nonres_div_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] D,
    input  logic [QW-1:0] Q,
    input  logic [RW:0]   R_n1,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [QW-1:0] quo,
    output logic [DW-1:0] rem,
    output logic          fixed,
    output logic          dz
`ifdef NONRES_FIXUP_SELFCHECK_EN
    ,
    input  logic [RW-1:0] R_0,
    output logic          chk_err
`endif
);

    logic     rdy_en;
    logic     s1_v;
    logic     s2_v;
    logic     s2_en;
    logic     s1_fire;
    logic     in_fire;
    nrd_raw_t raw_in;
    nrd_raw_t s1_q;
    nrd_res_t fix_res;
    nrd_res_t s2_q;

    always_comb begin
        raw_in      = '0;
        raw_in.d    = D;
        raw_in.q    = Q;
        raw_in.r_n1 = R_n1;
`ifdef NONRES_FIXUP_SELFCHECK_EN
        raw_in.r_0  = R_0;
`endif
    end

    // rdy_en keeps in_ready low through reset and the release edge.
    assign s2_en    = !s2_v || out_ready;
    assign s1_fire  = s1_v && s2_en;
    assign in_ready = rdy_en && (!s1_v || s2_en);
    assign in_fire  = in_valid && in_ready;

    nonres_rem_restore u_restore (
        .raw (s1_q),
        .res (fix_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en <= 1'b0;
            s1_v   <= 1'b0;
            s2_v   <= 1'b0;
            s1_q   <= '0;
            s2_q   <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (in_fire) begin
                s1_v <= 1'b1;
                s1_q <= raw_in;
            end else if (s1_fire) begin
                s1_v <= 1'b0;
            end
            if (s2_en) begin
                s2_v <= s1_v;
            end
            if (s1_fire) begin
                s2_q <= fix_res;
            end
        end
    end

    assign out_valid = s2_v;
    assign quo       = s2_q.quo;
    assign rem       = s2_q.rem;
    assign fixed     = s2_q.fixed;
    assign dz        = s2_q.dz;

`ifdef NONRES_FIXUP_SELFCHECK_EN
    logic [CW-1:0] recomb;
    logic          chk_bad;

    // Checked as the result enters S2; divide-by-zero has nothing to verify.
    always_comb begin
        recomb  = recombine(fix_res.quo, s1_q.d, fix_res.rem);
        chk_bad = !fix_res.dz &&
                  ((recomb != CW'(s1_q.r_0)) ||
                   (fix_res.rem >= s1_q.d));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_err <= 1'b0;
        end else if (s1_fire && chk_bad) begin
            chk_err <= 1'b1;
        end
    end
`endif

endmodule
